// File: rtl/sequential_alu.sv
// Multi-cycle signed ALU (add/sub/mul/div) with overflow flag and level-request / one-cycle-accept handshake.
// Iterative multiply/divide is built only when SEQUENTIAL_ALU_MULDIV_EN is defined.
module sequential_alu #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_add,
    input  logic                  i_sub,
    input  logic                  i_mul,
    input  logic                  i_div,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_ovf,
    output logic                  o_accept
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t       r_state, w_state_next;
    op_t          r_op, w_op_req;
    logic         w_req;
    logic         w_start;
    logic         w_last;
    logic [W-1:0] r_a, r_b;
    logic [W-1:0] r_q;
    logic         r_ovf;
    logic         r_accept;
    logic [W:0]   w_sum;
    logic [W-1:0] w_neg_b;
    logic         w_b_min;
    logic [W-1:0] w_val;
    logic         w_res_ovf;

    // Request decode with fixed priority add > sub > mul > div.
    always_comb begin
        w_req    = i_add | i_sub | i_mul | i_div;
        w_op_req = OP_DIV;
        if (i_add)      w_op_req = OP_ADD;
        else if (i_sub) w_op_req = OP_SUB;
        else if (i_mul) w_op_req = OP_MUL;
        w_start = (r_state == S_IDLE) && w_req;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req)  w_state_next = S_EXEC;
            S_EXEC:  if (w_last) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Subtract is A + (-B); negating MIN wraps, so B == MIN is flagged separately.
    always_comb begin
        w_b_min = (r_b == MIN_VAL);
        w_neg_b = -r_b;
        w_sum   = {r_a[W-1], r_a} +
                  ((r_op == OP_SUB) ? {w_neg_b[W-1], w_neg_b} : {r_b[W-1], r_b});
    end

`ifdef SEQUENTIAL_ALU_MULDIV_EN
    localparam int CNT_W = $clog2(W);

    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_acc, w_acc_next;
    logic [W-1:0]     r_ma, r_mb, w_mb_next;
    logic [W:0]       w_rem_sh, w_diff;
    logic [W-1:0]     w_abs_a, w_abs_b;
    logic [W-1:0]     w_mag;
    logic             w_neg_res;

    // r_ma holds the fixed magnitude (multiplicand / divisor); r_mb is shifted out
    // MSB-first (multiplier / dividend) and collects quotient bits during divide.
    always_comb begin
        w_abs_a   = i_a[W-1] ? -i_a : i_a;
        w_abs_b   = i_b[W-1] ? -i_b : i_b;
        w_rem_sh  = {r_acc[W-1:0], r_mb[W-1]};
        w_diff    = w_rem_sh - {1'b0, r_ma};
        w_neg_res = r_a[W-1] ^ r_b[W-1];
        if (r_op == OP_MUL) begin
            w_acc_next = (r_acc << 1) + (r_mb[W-1] ? {{W{1'b0}}, r_ma} : '0);
            w_mb_next  = {r_mb[W-2:0], 1'b0};
        end else begin
            w_acc_next = w_diff[W] ? {{(W-1){1'b0}}, w_rem_sh} : {{(W-1){1'b0}}, w_diff};
            w_mb_next  = {r_mb[W-2:0], ~w_diff[W]};
        end
        w_mag  = (r_op == OP_MUL) ? w_acc_next[W-1:0] : w_mb_next;
        w_last = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_cnt == '0);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ma  <= '0;
            r_mb  <= '0;
        end else if (w_start) begin
            r_cnt <= CNT_W'(W - 1);
            r_acc <= '0;
            r_ma  <= (w_op_req == OP_MUL) ? w_abs_a : w_abs_b;
            r_mb  <= (w_op_req == OP_MUL) ? w_abs_b : w_abs_a;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= w_acc_next;
            r_mb  <= w_mb_next;
        end
    end
`else
    assign w_last = 1'b1;
`endif

    always_comb begin
        w_res_ovf = 1'b1;
        w_val     = '0;
        case (r_op)
            OP_ADD: begin
                w_res_ovf = w_sum[W] ^ w_sum[W-1];
                w_val     = w_sum[W-1:0];
            end
            OP_SUB: begin
                w_res_ovf = (w_sum[W] ^ w_sum[W-1]) | w_b_min;
                w_val     = w_sum[W-1:0];
            end
`ifdef SEQUENTIAL_ALU_MULDIV_EN
            // A product magnitude of exactly 2^(W-1) is flagged even when negative.
            OP_MUL: begin
                w_res_ovf = |w_acc_next[2*W-1:W-1];
                w_val     = w_neg_res ? -w_mag : w_mag;
            end
            OP_DIV: begin
                w_res_ovf = (r_b == '0) | (r_a == MIN_VAL) | w_b_min;
                w_val     = w_neg_res ? -w_mag : w_mag;
            end
`endif
            default: begin
                w_res_ovf = 1'b1;
                w_val     = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_q      <= '0;
            r_ovf    <= 1'b0;
            r_accept <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            if (w_start) begin
                r_op <= w_op_req;
                r_a  <= i_a;
                r_b  <= i_b;
            end
            if ((r_state == S_EXEC) && w_last) begin
                r_q      <= w_res_ovf ? '0 : w_val;
                r_ovf    <= w_res_ovf;
                r_accept <= 1'b1;
            end
        end
    end

    assign o_q      = r_q;
    assign o_ovf    = r_ovf;
    assign o_accept = r_accept;

endmodule

// File: tb/tb_sequential_alu.sv
// Self-checking bench for sequential_alu (W=4): directed corner cases plus randomized ops
// against an integer-arithmetic reference model; honours SEQUENTIAL_ALU_MULDIV_EN.
module tb_sequential_alu;

    localparam int W    = 4;
    localparam int MAXV = 7;
    localparam int MINV = -8;
`ifdef SEQUENTIAL_ALU_MULDIV_EN
    localparam int MD_LAT = W;
    localparam bit MD_EN  = 1'b1;
`else
    localparam int MD_LAT = 1;
    localparam bit MD_EN  = 1'b0;
`endif

    logic         i_clk  = 1'b0;
    logic         i_nrst = 1'b0;
    logic [W-1:0] i_a    = '0;
    logic [W-1:0] i_b    = '0;
    logic         i_add  = 1'b0;
    logic         i_sub  = 1'b0;
    logic         i_mul  = 1'b0;
    logic         i_div  = 1'b0;
    logic [W-1:0] o_q;
    logic         o_ovf;
    logic         o_accept;

    int n_checks = 0;
    int n_pass   = 0;

    sequential_alu #(.DATA_WIDTH(W)) dut (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_add    (i_add),
        .i_sub    (i_sub),
        .i_mul    (i_mul),
        .i_div    (i_div),
        .o_q      (o_q),
        .o_ovf    (o_ovf),
        .o_accept (o_accept)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Returns {ovf, q}; op 0=add 1=sub 2=mul 3=div. SV int division truncates toward zero.
    function automatic logic [W:0] model(input int op, input int a, input int b);
        int          r;
        logic        ovf;
        logic [31:0] rv;
        ovf = 1'b0;
        r   = 0;
        case (op)
            0: r = a + b;
            1: begin
                r = a - b;
                if (b == MINV) ovf = 1'b1;
            end
            2: begin
                r = a * b;
                if (r > MAXV || r < -MAXV) ovf = 1'b1;
            end
            default: begin
                if (b == 0 || a == MINV || b == MINV) ovf = 1'b1;
                else r = a / b;
            end
        endcase
        if (r > MAXV || r < MINV) ovf = 1'b1;
        if (op >= 2 && !MD_EN) ovf = 1'b1;
        rv = r;
        return ovf ? {1'b1, {W{1'b0}}} : {1'b0, rv[W-1:0]};
    endfunction

    function automatic int rand_s();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    // Issues one request from IDLE, optionally scrambles inputs during EXEC, checks latency,
    // result, flag and that accept is a single-cycle pulse.
    task automatic run_op(input string tag, input logic [3:0] strobes, input int a, input int b,
                          input bit scramble);
        int         op;
        int         exp_lat;
        int         lat;
        logic [W:0] exp;
        op      = strobes[0] ? 0 : strobes[1] ? 1 : strobes[2] ? 2 : 3;
        exp     = model(op, a, b);
        exp_lat = (op < 2) ? 1 : MD_LAT;
        i_a     = W'(a);
        i_b     = W'(b);
        {i_div, i_mul, i_sub, i_add} = strobes;
        @(posedge i_clk);
        #1;
        if (scramble) begin
            i_a = W'($urandom);
            i_b = W'($urandom);
            {i_div, i_mul, i_sub, i_add} = 4'($urandom);
        end
        lat = 0;
        do begin
            @(posedge i_clk);
            #1;
            lat++;
        end while (!o_accept && lat < 40);
        {i_div, i_mul, i_sub, i_add} = 4'b0000;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_q"}, o_q, exp[W-1:0]);
        check({tag, "_ovf"}, o_ovf, exp[W]);
        @(posedge i_clk);
        #1;
        check({tag, "_pulse"}, o_accept, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int         a;
        int         b;
        int         lat;
        bit         seen;
        logic [W:0] exp;

        repeat (2) @(posedge i_clk);
        #1;
        check("rst_q", o_q, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_accept", o_accept, 0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        @(negedge i_clk);

        run_op("add_2_3", 4'b0001, 2, 3, 1'b0);
        run_op("add_7_1", 4'b0001, 7, 1, 1'b0);
        run_op("sub_m3_2", 4'b0010, -3, 2, 1'b0);
        run_op("sub_3_m8", 4'b0010, 3, -8, 1'b0);
        run_op("sub_m8_1", 4'b0010, -8, 1, 1'b0);
        run_op("sub_m1_m8", 4'b0010, -1, -8, 1'b0);
        run_op("mul_3_m2", 4'b0100, 3, -2, 1'b0);
        run_op("mul_2_m4", 4'b0100, 2, -4, 1'b0);
        run_op("mul_m8_1", 4'b0100, -8, 1, 1'b0);
        run_op("mul_m7_m1", 4'b0100, -7, -1, 1'b0);
        run_op("div_7_m2", 4'b1000, 7, -2, 1'b0);
        run_op("div_m7_7", 4'b1000, -7, 7, 1'b0);
        run_op("div_5_0", 4'b1000, 5, 0, 1'b0);
        run_op("div_m8_1", 4'b1000, -8, 1, 1'b0);
        run_op("div_1_m8", 4'b1000, 1, -8, 1'b0);
        run_op("prio_all", 4'b1111, 2, 3, 1'b0);
        run_op("prio_sub", 4'b1110, 2, 3, 1'b0);
        run_op("prio_mul", 4'b1100, 2, 3, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op($sformatf("rnd%0d", k), 4'($urandom_range(1, 15)), rand_s(), rand_s(), 1'b1);
        end

        a     = rand_s();
        b     = rand_s();
        i_a   = W'(a);
        i_b   = W'(b);
        i_add = 1'b1;
        @(posedge i_clk);
        for (int k = 0; k < 6; k++) begin
            lat = 0;
            do begin
                @(posedge i_clk);
                #1;
                lat++;
            end while (!o_accept && lat < 40);
            exp = model(0, a, b);
            check($sformatf("hold%0d_lat", k), lat, (k == 0) ? 1 : 3);
            check($sformatf("hold%0d_q", k), o_q, exp[W-1:0]);
            check($sformatf("hold%0d_ovf", k), o_ovf, exp[W]);
            a   = rand_s();
            b   = rand_s();
            i_a = W'(a);
            i_b = W'(b);
        end
        i_add = 1'b0;
        @(posedge i_clk);
        #1;

        run_op("pre_rst", 4'b0001, 2, 3, 1'b0);
        i_a   = W'(3);
        i_b   = W'(-2);
        i_mul = 1'b1;
        @(posedge i_clk);
        if (MD_LAT > 1) @(posedge i_clk);
        #1;
        i_nrst = 1'b0;
        i_mul  = 1'b0;
        #1;
        check("abort_q", o_q, 0);
        check("abort_ovf", o_ovf, 0);
        check("abort_accept", o_accept, 0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        seen   = 1'b0;
        repeat (W + 4) begin
            @(posedge i_clk);
            #1;
            if (o_accept) seen = 1'b1;
        end
        check("abort_no_accept", seen, 0);
        run_op("post_rst_mul", 4'b0100, 3, -2, 1'b0);
        run_op("post_rst_add", 4'b0001, -4, -4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sequential_alu.md
# sequential_alu

Multi-cycle signed two's-complement ALU with four operations: add, subtract, multiply and divide. It flags arithmetic overflow and uses a level-request / single-cycle-accept handshake. It sits as a shared arithmetic resource behind a simple controller that holds an operation strobe until the result is accepted. Multiply and divide are iterative, one bit per cycle; add and subtract take a single execute cycle.

## Interface
- DATA_WIDTH, 4, operand and result width in bits, signed two's complement; must be ≥ 2.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_nrst  in  1  reset; asynchronous, active-low.
- i_a  in  DATA_WIDTH  operand A (dividend / minuend), signed.
- i_b  in  DATA_WIDTH  operand B (divisor / subtrahend), signed.
- i_add  in  1  request A+B.
- i_sub  in  1  request A−B.
- i_mul  in  1  request A×B.
- i_div  in  1  request A÷B.
- o_q  out  DATA_WIDTH  result, registered.
- o_ovf  out  1  overflow / invalid flag for o_q, registered.
- o_accept  out  1  one-cycle pulse; o_q and o_ovf are valid while it is high.

## Operation
- Reset: FSM goes to IDLE; o_q=0, o_ovf=0, o_accept=0. Reset mid-operation aborts it and produces no accept.
- FSM states: IDLE → EXEC → DONE → IDLE.
- IDLE: on a rising edge with any strobe high, latch i_a, i_b and the op, then go to EXEC.
  - Priority when several strobes are high: add > sub > mul > div.
- During EXEC, operand or strobe changes are ignored. A dropped strobe does not cancel the operation.
- Add: result = A+B. ovf=1 if the true sum is outside [MIN, MAX], where MIN = −2^(W−1) and MAX = 2^(W−1)−1.
- Sub: computed as A+(−B). ovf=1 if the true difference is out of range, or if B==MIN (negation overflow).
- Mul: sign-magnitude shift-add on |A| and |B| (W-bit unsigned magnitudes), producing a 2W-bit magnitude product with sign = sign(A) XOR sign(B).
  - ovf=1 if the product magnitude > MAX. A product of exactly MIN is therefore flagged.
- Div: restoring division on magnitudes; quotient truncates toward zero; remainder is discarded.
  - ovf=1 if B==0, A==MIN or B==MIN.
- Whenever ovf=1, o_q=0. Otherwise o_q is the exact W-bit signed result.
- DONE: o_accept=1 for exactly one cycle, then return to IDLE. No new request is sampled on the edge that leaves DONE.
- o_q and o_ovf hold their values until the next DONE.

## Timing
- Request sampled at edge N (IDLE).
- Add/sub: EXEC occupies one cycle; o_accept is high from edge N+1 to N+2.
- Mul/div: EXEC occupies DATA_WIDTH cycles; o_accept is high from edge N+W to N+W+1.
- Minimum issue interval: add/sub every 3 cycles; mul/div every W+2 cycles.
- A strobe held high continuously across accepts is re-sampled at the first IDLE edge after DONE. The controller changes operands in the cycle o_accept is high.
- o_accept, o_q and o_ovf are driven from registers only; there is no combinational path from inputs.

## Configuration
- SEQUENTIAL_ALU_MULDIV_EN defined: multiply and divide are implemented as specified above.
- SEQUENTIAL_ALU_MULDIV_EN undefined: the iterative datapath is omitted.
  - i_mul and i_div requests complete with add/sub latency (accept at N+1), returning o_ovf=1 and o_q=0.
  - Add/sub behaviour is unchanged.

## Test plan
- W=4, add(2,3) → accept after 1 EXEC cycle, o_q=5, o_ovf=0. add(7,1) → o_ovf=1, o_q=0.
- sub(−3,2) → o_q=0xB (−5), o_ovf=0. sub(3,−8) → o_ovf=1. sub(−8,1) → o_ovf=1.
- mul(3,−2) → o_q=0xA (−6) after 4 EXEC cycles. mul(2,−4) → o_ovf=1 (result MIN). mul(−8,1) → o_ovf=1.
- div(7,−2) → o_q=0xD (−3). div(−7,7) → o_q=0xF. div(5,0), div(−8,1) and div(1,−8) → o_ovf=1, o_q=0.
- Hold i_add high with new operands presented each accept cycle → one accept per 3 cycles; each result matches its own operands.
- Drive i_nrst low during the 2nd EXEC cycle of a mul → o_q=0, o_ovf=0, no accept. After release, a fresh request completes normally.
